// File: rtl/psum_requant_pkg.sv
// psum_requant_pkg
//   Shared constants, FSM state type and the round/saturate helper used by
//   the psum_requant top and its per-lane accumulator.
//   No ports (package).

package psum_requant_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int SA_LENGTH  = 256;
    localparam int ACC_WIDTH  = 32;
    localparam int S          = 7;
    localparam int TILE_W     = 8;

    localparam int SAT_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_WIDTH - 1));
    localparam int RND     = 2 ** (S - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Rescale from 2S to S fractional bits, round half up, clamp to the
    // output range. One guard bit keeps the rounding add from wrapping.
    function automatic logic signed [DATA_WIDTH-1:0] sat_round(
        input logic signed [ACC_WIDTH-1:0] v
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] r;
        ext = $signed({v[ACC_WIDTH-1], v}) + $signed((ACC_WIDTH + 1)'(RND));
        r   = ext >>> S;
        if (r > $signed((ACC_WIDTH + 1)'(SAT_MAX)))
            sat_round = DATA_WIDTH'(SAT_MAX);
        else if (r < $signed((ACC_WIDTH + 1)'(SAT_MIN)))
            sat_round = DATA_WIDTH'(SAT_MIN);
        else
            sat_round = r[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/psum_requant_if.sv
// psum_requant_if
//   Data/handshake bundle between the systolic array, the requantizer and
//   the activation stage.
//   num_tiles, in_valid, psum_in : array side -> requantizer
//   out, out_valid, busy         : requantizer -> activation stage
//   slave  : the requantizer view
//   master : the producer/consumer (or bench) view

interface psum_requant_if
    import psum_requant_pkg::*;
();
    logic [TILE_W-1:0]            num_tiles;
    logic                         in_valid;
    logic signed [ACC_WIDTH-1:0]  psum_in [SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] out     [SA_LENGTH];
    logic                         out_valid;
    logic                         busy;

    modport slave (
        input  num_tiles, in_valid, psum_in,
        output out, out_valid, busy
    );

    modport master (
        output num_tiles, in_valid, psum_in,
        input  out, out_valid, busy
    );
endinterface

// File: rtl/psum_requant_lane.sv
// psum_requant_lane
//   One output element: accumulator register plus round/saturate output
//   register.
//   clk, async_rst (active-low), sync_rst (active-high)
//   load : first beat of a group, acc takes psum directly
//   add  : later beat of a group, acc += psum
//   emit : register the requantized final sum into out
//   psum : partial sum for this lane
//   out  : requantized, registered output element

module psum_requant_lane
    import psum_requant_pkg::*;
(
    input  logic                         clk,
    input  logic                         async_rst,
    input  logic                         sync_rst,
    input  logic                         load,
    input  logic                         add,
    input  logic                         emit,
    input  logic signed [ACC_WIDTH-1:0]  psum,
    output logic signed [DATA_WIDTH-1:0] out
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;

    // Final sum includes the current beat so emission needs no extra cycle.
    always_comb begin
        sum = load ? psum : acc + psum;
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            acc <= '0;
            out <= '0;
        end else if (sync_rst) begin
            acc <= '0;
            out <= '0;
        end else begin
            if (load || add)
                acc <= sum;
            if (emit)
                out <= sat_round(sum);
        end
    end

endmodule

// File: rtl/psum_requant.sv
// psum_requant
//   Sums partial-sum vectors over num_tiles K-tiles, requantizes each
//   element from 2S to S fractional bits and emits one registered vector
//   with a one-cycle out_valid pulse.
//   clk       : clock, rising edge
//   async_rst : asynchronous reset, active-low
//   sync_rst  : synchronous reset, active-high, wins over en
//   en        : clock enable; low freezes state and ignores in_valid
//   bus       : psum_requant_if.slave (num_tiles, in_valid, psum_in,
//               out, out_valid, busy)
//
//   state | meaning
//   IDLE  | no group in progress; next accepted beat loads acc
//   ACCUM | group in progress; cnt beats taken of tgt

module psum_requant
    import psum_requant_pkg::*;
(
    input  logic           clk,
    input  logic           async_rst,
    input  logic           sync_rst,
    input  logic           en,
    psum_requant_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'(ST_IDLE);
    localparam logic [0:0] ACCUM = 1'(ST_ACCUM);

    logic [0:0]        state;
    logic [TILE_W-1:0] cnt;
    logic [TILE_W-1:0] tgt;
    logic              out_valid;
    logic              busy;

    logic              accept;
    logic              first;
    logic              beat_acc;
    logic [TILE_W-1:0] eff_tiles;
    logic [TILE_W-1:0] cnt_nxt;
    logic              emit;

    logic signed [DATA_WIDTH-1:0] lane_out [SA_LENGTH];

    always_comb begin
        accept    = en & bus.in_valid;
        first     = accept & (state == IDLE);
        beat_acc  = accept & (state == ACCUM);
        eff_tiles = (bus.num_tiles == '0) ? TILE_W'(1) : bus.num_tiles;
        cnt_nxt   = cnt + 1'b1;
        emit      = (first & (eff_tiles == TILE_W'(1)))
                  | (beat_acc & (cnt_nxt == tgt));
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (sync_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // emit is already gated by en, so the pulse drops even when frozen
            out_valid <= emit;
            if (first) begin
                tgt <= eff_tiles;
                cnt <= TILE_W'(1);
                if (eff_tiles == TILE_W'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= ACCUM;
                    busy  <= 1'b1;
                end
            end else if (beat_acc) begin
                cnt <= cnt_nxt;
                if (cnt_nxt == tgt) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
        psum_requant_lane u_lane (
            .clk       (clk),
            .async_rst (async_rst),
            .sync_rst  (sync_rst),
            .load      (first),
            .add       (beat_acc),
            .emit      (emit),
            .psum      (bus.psum_in[i]),
            .out       (lane_out[i])
        );
    end

    assign bus.out       = lane_out;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_psum_requant.sv
// tb_psum_requant
//   Directed bench for psum_requant with hand-computed expected values.

module tb_psum_requant;
    import psum_requant_pkg::*;

    logic clk;
    logic async_rst;
    logic sync_rst;
    logic en;

    int errors;
    int checks;

    psum_requant_if bus ();

    psum_requant dut (
        .clk       (clk),
        .async_rst (async_rst),
        .sync_rst  (sync_rst),
        .en        (en),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compares every lane against one value; reports the first offending lane.
    task automatic chk_vec(input string tag, input int exp);
        int idx;
        idx = 0;
        for (int i = SA_LENGTH - 1; i >= 0; i--)
            if (bus.out[i] !== DATA_WIDTH'(exp)) idx = i;
        chk(tag, int'(bus.out[idx]), exp);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < SA_LENGTH; i++) bus.psum_in[i] = v;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        async_rst     = 1'b0;
        sync_rst      = 1'b0;
        en            = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num_tiles = '0;
        set_all(0);
        cyc();
        cyc();
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk_vec("reset_out", 0);
        async_rst = 1'b1;
        cyc();

        // accumulate 3 x 1.0 -> 3.0
        bus.num_tiles = 3;
        bus.in_valid  = 1'b1;
        set_all(16384);
        cyc();
        chk("acc_b1_busy", int'(bus.busy), 1);
        chk("acc_b1_ov", int'(bus.out_valid), 0);
        cyc();
        chk("acc_b2_busy", int'(bus.busy), 1);
        chk("acc_b2_ov", int'(bus.out_valid), 0);
        cyc();
        bus.in_valid = 1'b0;
        chk("acc_b3_ov", int'(bus.out_valid), 1);
        chk("acc_b3_busy", int'(bus.busy), 0);
        chk_vec("acc_out", 384);
        cyc();
        chk("acc_pulse_end", int'(bus.out_valid), 0);
        chk_vec("acc_out_hold", 384);

        // round / saturate
        bus.num_tiles = 1;
        set_all(0);
        bus.psum_in[0] = 64;
        bus.psum_in[1] = 63;
        bus.psum_in[2] = -64;
        bus.psum_in[3] = -65;
        bus.psum_in[4] = 200000;
        bus.psum_in[5] = -200000;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("rs_ov", int'(bus.out_valid), 1);
        chk("rs_64", int'(bus.out[0]), 1);
        chk("rs_63", int'(bus.out[1]), 0);
        chk("rs_m64", int'(bus.out[2]), 0);
        chk("rs_m65", int'(bus.out[3]), -1);
        chk("rs_satp", int'(bus.out[4]), 1023);
        chk("rs_satn", int'(bus.out[5]), -1024);
        chk("rs_other", int'(bus.out[6]), 0);
        cyc();

        // gaps and enable
        bus.num_tiles = 2;
        set_all(12800);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("gap_b1_ov", int'(bus.out_valid), 0);
        chk("gap_b1_busy", int'(bus.busy), 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("gap_idle_ov", int'(bus.out_valid), 0);
        end
        en = 1'b0;
        bus.in_valid = 1'b1;
        set_all(99999);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("gap_frozen_ov", int'(bus.out_valid), 0);
            chk("gap_frozen_busy", int'(bus.busy), 1);
        end
        en = 1'b1;
        set_all(3584);
        cyc();
        bus.in_valid = 1'b0;
        chk("gap_emit_ov", int'(bus.out_valid), 1);
        chk_vec("gap_out", 128);
        cyc();
        chk("gap_single_pulse", int'(bus.out_valid), 0);

        // back-to-back single-tile groups
        bus.num_tiles = 1;
        bus.in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_all(128 * k);
            cyc();
            chk("b2b_ov", int'(bus.out_valid), 1);
            chk_vec("b2b_out", k);
        end
        bus.in_valid = 1'b0;
        en = 1'b0;
        cyc();
        chk("b2b_en_low_ov", int'(bus.out_valid), 0);
        chk_vec("b2b_en_low_hold", 4);
        en = 1'b1;

        // num_tiles = 0 acts as 1
        bus.num_tiles = 0;
        set_all(640);
        bus.in_valid = 1'b1;
        cyc();
        chk("nt0_ov", int'(bus.out_valid), 1);
        chk_vec("nt0_out", 5);

        // target latched on first beat
        bus.num_tiles = 2;
        set_all(256);
        cyc();
        chk("latch_b1_ov", int'(bus.out_valid), 0);
        bus.num_tiles = 5;
        cyc();
        bus.in_valid = 1'b0;
        chk("latch_b2_ov", int'(bus.out_valid), 1);
        chk("latch_b2_busy", int'(bus.busy), 0);
        chk_vec("latch_out", 4);
        cyc();

        // async reset mid-group
        bus.num_tiles = 3;
        set_all(16384);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("ar_pre_busy", int'(bus.busy), 1);
        #1 async_rst = 1'b0;
        #1;
        chk("ar_busy", int'(bus.busy), 0);
        chk_vec("ar_out", 0);
        #1 async_rst = 1'b1;
        set_all(128);
        bus.in_valid = 1'b1;
        cyc();
        chk("ar_g_b1_ov", int'(bus.out_valid), 0);
        cyc();
        chk("ar_g_b2_ov", int'(bus.out_valid), 0);
        cyc();
        bus.in_valid = 1'b0;
        chk("ar_g_b3_ov", int'(bus.out_valid), 1);
        chk_vec("ar_g_out", 3);
        cyc();

        // sync reset mid-group
        set_all(16384);
        bus.in_valid = 1'b1;
        cyc();
        chk("sr_pre_busy", int'(bus.busy), 1);
        sync_rst = 1'b1;
        cyc();
        sync_rst = 1'b0;
        chk("sr_busy", int'(bus.busy), 0);
        chk("sr_ov", int'(bus.out_valid), 0);
        chk_vec("sr_out", 0);
        set_all(256);
        cyc();
        chk("sr_g_b1_ov", int'(bus.out_valid), 0);
        cyc();
        chk("sr_g_b2_ov", int'(bus.out_valid), 0);
        cyc();
        bus.in_valid = 1'b0;
        chk("sr_g_b3_ov", int'(bus.out_valid), 1);
        chk_vec("sr_g_out", 6);
        cyc();
        chk("sr_g_end_ov", int'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
